// File: rtl/aud_pkg.sv
// Shared types and constants for the audio playback DSP.
// Holds mode/state enums and the Q1.15 reciprocal helper.
package aud_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_FAST       = 2'd1,
    MODE_SLOW_CONST = 2'd2,
    MODE_SLOW_LIN   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam int RCP_W = 17;

  // round(32768/n); n=1 gives 32768, hence 17 bits.
  function automatic logic [RCP_W-1:0] recip(input int n);
    return RCP_W'((32768 + n / 2) / n);
  endfunction

endpackage

// File: rtl/aud_lrck_edge.sv
// DAC LR clock synchroniser and falling-edge detector.
// In: i_clk, i_rst_n, i_lrck (async). Out: o_tick (1 cycle).
module aud_lrck_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lrck,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  if (SYNC_STAGES == 1) begin : g_s1
    assign sync_d = i_lrck;
  end else begin : g_sn
    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_lrck};
  end

  assign dly_d  = sync_q[SYNC_STAGES-1];
  assign o_tick = ~sync_q[SYNC_STAGES-1] & dly_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

endmodule

// File: rtl/aud_play_dsp.sv
// Audio playback DSP: SRAM fetch, speed/interp, one sample per LRCK fall.
// In: ctrl, mode/speed/window, i_daclrck, i_sram_data. Out: SRAM rd, DAC, busy/done.
module aud_play_dsp
  import aud_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int SPD_W       = 3,
  parameter int SRAM_LAT    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic              i_reverse,
  input  logic              i_daclrck,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_rd,
  output logic [DATA_W-1:0] o_dac_data,
  output logic              o_dac_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int KW   = SPD_W + 1;
  localparam int NMAX = 1 << SPD_W;
  localparam int DW1  = DATA_W + 1;
  localparam int AW1  = ADDR_W + 1;
  localparam int PW   = DW1 + KW + RCP_W;

  logic tick;

  aud_lrck_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_lrck (i_daclrck),
    .o_tick (tick)
  );

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [SPD_W-1:0]    spd_q, spd_d;
  logic                rev_q, rev_d;
  logic [ADDR_W-1:0]   sa_q, sa_d;
  logic [ADDR_W-1:0]   ea_q, ea_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   curr_q, curr_d;
  logic [DATA_W-1:0]   dac_q, dac_d;
  logic [KW-1:0]       k_q, k_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                rd_q, rd_d;
  logic                pend_q, pend_d;
  logic [SRAM_LAT-1:0] lat_q, lat_d, lat_nxt;
  logic                cap;

  // Read-latency shift register: top bit marks i_sram_data valid.
  if (SRAM_LAT == 1) begin : g_lat1
    assign lat_nxt = rd_q;
  end else begin : g_latn
    assign lat_nxt = {lat_q[SRAM_LAT-2:0], rd_q};
  end

  assign cap = lat_q[SRAM_LAT-1];

  logic [RCP_W-1:0] rcp_tab [NMAX];

  for (genvar i = 0; i < NMAX; i++) begin : g_rcp
    assign rcp_tab[i] = recip(i + 1);
  end

  logic [KW-1:0]      n_w, k_inc, hold;
  logic [AW1-1:0]     step, fwd_nxt, rev_lim;
  logic               slow, lin, seg_end, win_end;
  logic [DW1-1:0]     diff;
  logic signed [PW-1:0] d_x, k_x, r_x, prod;
  logic [DATA_W-1:0]  interp, samp;

  assign n_w   = {1'b0, spd_q} + KW'(1);
  assign k_inc = k_q + KW'(1);
  assign slow  = mode_q[1];
  assign lin   = mode_q == MODE_SLOW_LIN;
  assign hold  = slow ? n_w : KW'(1);
  assign step  = (mode_q == MODE_FAST) ? AW1'(n_w) : AW1'(1);

  // One extra bit catches address carry-out at the window edge.
  assign fwd_nxt = {1'b0, addr_q} + step;
  assign rev_lim = {1'b0, sa_q} + step;
  assign win_end = rev_q ? ({1'b0, addr_q} < rev_lim)
                         : (fwd_nxt > {1'b0, ea_q});
  assign seg_end = k_inc == hold;

  assign diff = {curr_q[DATA_W-1], curr_q}
              - {prev_q[DATA_W-1], prev_q};
  assign d_x  = {{(PW-DW1){diff[DW1-1]}}, diff};
  assign k_x  = {{(PW-KW){1'b0}}, k_inc};
  assign r_x  = {{(PW-RCP_W){1'b0}}, rcp_tab[spd_q]};
  assign prod = d_x * k_x * r_x;

  assign interp = prev_q + DATA_W'(prod >>> 15);
  assign samp   = (lin && k_inc < n_w) ? interp : curr_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    spd_d   = spd_q;
    rev_d   = rev_q;
    sa_d    = sa_q;
    ea_d    = ea_q;
    addr_d  = addr_q;
    prev_d  = prev_q;
    curr_d  = curr_q;
    k_d     = k_q;
    dac_d   = dac_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    pend_d  = pend_q;
    lat_d   = lat_nxt;

    if (cap) curr_d = i_sram_data;

    unique case (state_q)
      ST_IDLE: begin
        dac_d = '0;
        if (!i_pause && i_start) begin
          if (i_start_addr > i_end_addr) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode_e'(i_mode);
            spd_d   = i_speed;
            rev_d   = i_reverse;
            sa_d    = i_start_addr;
            ea_d    = i_end_addr;
            addr_d  = i_reverse ? i_end_addr
                                : i_start_addr;
            prev_d  = '0;
            curr_d  = '0;
            k_d     = '0;
            pend_d  = 1'b0;
            rd_d    = 1'b1;
            state_d = ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        if (i_pause) pend_d = 1'b1;
        if (cap) begin
          state_d = (pend_q || i_pause) ? ST_PAUSE
                                        : ST_RUN;
          pend_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_pause) begin
          state_d = ST_PAUSE;
          dac_d   = '0;
        end else if (tick) begin
          dac_d   = samp;
          valid_d = 1'b1;
          k_d     = k_inc;
          if (seg_end) begin
            prev_d = curr_q;
            k_d    = '0;
            mode_d = mode_e'(i_mode);
            spd_d  = i_speed;
            rev_d  = i_reverse;
            if (win_end) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              mode_d  = MODE_NORMAL;
              spd_d   = '0;
              rev_d   = 1'b0;
              sa_d    = '0;
              ea_d    = '0;
              addr_d  = '0;
              prev_d  = '0;
              curr_d  = '0;
            end else begin
              addr_d = rev_q ? addr_q - ADDR_W'(step)
                             : addr_q + ADDR_W'(step);
              rd_d   = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        dac_d = '0;
        if (!i_pause && i_start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_stop) begin
      state_d = ST_IDLE;
      mode_d  = MODE_NORMAL;
      spd_d   = '0;
      rev_d   = 1'b0;
      sa_d    = '0;
      ea_d    = '0;
      addr_d  = '0;
      prev_d  = '0;
      curr_d  = '0;
      k_d     = '0;
      dac_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      rd_d    = 1'b0;
      pend_d  = 1'b0;
      lat_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NORMAL;
      spd_q   <= '0;
      rev_q   <= 1'b0;
      sa_q    <= '0;
      ea_q    <= '0;
      addr_q  <= '0;
      prev_q  <= '0;
      curr_q  <= '0;
      k_q     <= '0;
      dac_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      pend_q  <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      spd_q   <= spd_d;
      rev_q   <= rev_d;
      sa_q    <= sa_d;
      ea_q    <= ea_d;
      addr_q  <= addr_d;
      prev_q  <= prev_d;
      curr_q  <= curr_d;
      k_q     <= k_d;
      dac_q   <= dac_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      lat_q   <= lat_d;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_sram_rd   = rd_q;
  assign o_dac_data  = dac_q;
  assign o_dac_valid = valid_q;
  assign o_busy      = state_q != ST_IDLE;
  assign o_done      = done_q;

endmodule

// File: tb/tb_aud_play_dsp.sv
// Testbench for aud_play_dsp: vector table plus hand sequences.
// SRAM model, LRCK driver and queue scoreboard on reads/samples.
module tb_aud_play_dsp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop = 1'b0;
  logic [1:0]  i_mode = '0;
  logic [2:0]  i_speed = '0;
  logic        i_reverse = 1'b0;
  logic        i_daclrck = 1'b0;
  logic [19:0] i_start_addr = '0;
  logic [19:0] i_end_addr = '0;
  logic [15:0] sram_data = '0;
  logic [19:0] o_sram_addr;
  logic        o_sram_rd;
  logic [15:0] o_dac_data;
  logic        o_dac_valid;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  aud_play_dsp dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_stop      (i_stop),
    .i_mode      (i_mode),
    .i_speed     (i_speed),
    .i_reverse   (i_reverse),
    .i_daclrck   (i_daclrck),
    .i_start_addr(i_start_addr),
    .i_end_addr  (i_end_addr),
    .i_sram_data (sram_data),
    .o_sram_addr (o_sram_addr),
    .o_sram_rd   (o_sram_rd),
    .o_dac_data  (o_dac_data),
    .o_dac_valid (o_dac_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  typedef struct {
    int mode;
    int spd;
    bit rev;
    int sa;
    int ea;
    int nsamp;
    int nrd;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int vcnt = 0;
  int rcnt = 0;
  int dacq[$];
  int rdq[$];
  int mem [256];
  vec_t vecs [10];

  always @(posedge clk)
    if (o_sram_rd) sram_data <= 16'(mem[o_sram_addr[7:0]]);

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_sram_rd) begin
        rcnt++;
        if (rdq.size() == 0)
          chk("unexp_rd", int'(o_sram_addr), -1);
        else
          chk("rd_addr", int'(o_sram_addr), rdq.pop_front());
      end
      if (o_dac_valid) begin
        vcnt++;
        if (dacq.size() == 0)
          chk("unexp_dac", int'($signed(o_dac_data)), 99999);
        else
          chk("dac", int'($signed(o_dac_data)), dacq.pop_front());
      end
      if (o_done) begin
        done_cnt++;
        chk("done_early", dacq.size(), 0);
      end
    end
  end

  task automatic lr_tick();
    i_daclrck = 1'b1;
    repeat (6) @(negedge clk);
    i_daclrck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic set_in(input int m, input int s, input bit r,
                        input int sa, input int ea);
    i_mode       = 2'(m);
    i_speed      = 3'(s);
    i_reverse    = r;
    i_start_addr = 20'(sa);
    i_end_addr   = 20'(ea);
    done_cnt     = 0;
    vcnt         = 0;
    rcnt         = 0;
  endtask

  task automatic model_push(input vec_t v);
    int n, s, h, a, cur, prv, rcp;
    longint p;
    n   = v.spd + 1;
    s   = (v.mode == 1) ? n : 1;
    h   = (v.mode >= 2) ? n : 1;
    rcp = (32768 + n / 2) / n;
    if (v.sa > v.ea) return;
    a   = v.rev ? v.ea : v.sa;
    prv = 0;
    for (int g = 0; g < 64; g++) begin
      rdq.push_back(a);
      cur = mem[a];
      for (int k = 1; k <= h; k++) begin
        if (v.mode == 3 && k < n) begin
          p = longint'(cur - prv) * k * rcp;
          dacq.push_back(int'(shortint'(prv + (p >>> 15))));
        end else begin
          dacq.push_back(cur);
        end
      end
      prv = cur;
      if (v.rev) begin
        if (a < v.sa + s) break;
        a -= s;
      end else begin
        if (a + s > v.ea) break;
        a += s;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    model_push(v);
    set_in(v.mode, v.spd, v.rev, v.sa, v.ea);
    pulse_start();
    repeat (2) @(negedge clk);
    for (int t = 0; t < 100 && done_cnt == 0; t++) lr_tick();
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_done", idx), done_cnt, 1);
    chk($sformatf("v%0d_nsamp", idx), vcnt, v.nsamp);
    chk($sformatf("v%0d_nrd", idx), rcnt, v.nrd);
    chk($sformatf("v%0d_qleft", idx), dacq.size() + rdq.size(), 0);
    chk($sformatf("v%0d_busy", idx), int'(o_busy), 0);
    chk($sformatf("v%0d_dac0", idx), int'(o_dac_data), 0);
    dacq.delete();
    rdq.delete();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = a * 100;
    mem[32] = -1000;

    vecs[0] = '{0, 0, 1'b0, 16, 19, 4, 4};
    vecs[1] = '{1, 2, 1'b0, 0, 9, 4, 4};
    vecs[2] = '{2, 1, 1'b1, 5, 7, 6, 3};
    vecs[3] = '{3, 3, 1'b0, 10, 12, 12, 3};
    vecs[4] = '{3, 2, 1'b1, 30, 33, 12, 4};
    vecs[5] = '{0, 0, 1'b0, 48, 48, 1, 1};
    vecs[6] = '{0, 0, 1'b0, 64, 63, 0, 0};
    vecs[7] = '{1, 7, 1'b0, 0, 20, 3, 3};
    vecs[8] = '{1, 1, 1'b1, 3, 8, 3, 3};
    vecs[9] = '{3, 7, 1'b0, 32, 32, 8, 1};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_rd", int'(o_sram_rd), 0);
    chk("rst_dac", int'(o_dac_data), 0);
    chk("rst_done", int'(o_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // SLOW_LIN N=4 toward a negative sample
    set_in(3, 3, 1'b0, 32, 32);
    rdq.push_back(32);
    dacq.push_back(-250);
    dacq.push_back(-500);
    dacq.push_back(-750);
    dacq.push_back(-1000);
    pulse_start();
    for (int t = 0; t < 10 && done_cnt == 0; t++) lr_tick();
    repeat (3) @(negedge clk);
    chk("neg_done", done_cnt, 1);
    chk("neg_nsamp", vcnt, 4);

    // pause after k=2 then resume
    set_in(3, 3, 1'b0, 10, 10);
    rdq.push_back(10);
    dacq.push_back(250);
    dacq.push_back(500);
    pulse_start();
    lr_tick();
    lr_tick();
    @(negedge clk);
    i_pause = 1'b1;
    @(negedge clk);
    i_pause = 1'b0;
    repeat (2) @(negedge clk);
    chk("p_busy", int'(o_busy), 1);
    chk("p_dac0", int'(o_dac_data), 0);
    lr_tick();
    chk("p_novalid", vcnt, 2);
    chk("p_dac0b", int'(o_dac_data), 0);
    dacq.push_back(750);
    dacq.push_back(1000);
    pulse_start();
    for (int t = 0; t < 10 && done_cnt == 0; t++) lr_tick();
    repeat (3) @(negedge clk);
    chk("p_done", done_cnt, 1);
    chk("p_nsamp", vcnt, 4);
    chk("p_qleft", dacq.size(), 0);

    // pause and stop together
    set_in(0, 0, 1'b0, 16, 19);
    rdq.push_back(16);
    rdq.push_back(17);
    dacq.push_back(1600);
    pulse_start();
    lr_tick();
    @(negedge clk);
    i_pause = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_pause = 1'b0;
    i_stop  = 1'b0;
    repeat (3) @(negedge clk);
    chk("s_busy", int'(o_busy), 0);
    chk("s_dac0", int'(o_dac_data), 0);
    lr_tick();
    chk("s_nodone", done_cnt, 0);
    chk("s_nsamp", vcnt, 1);
    chk("s_nrd", rcnt, 2);

    // reset mid-RUN
    set_in(0, 0, 1'b0, 16, 19);
    rdq.push_back(16);
    rdq.push_back(17);
    dacq.push_back(1600);
    pulse_start();
    i_daclrck = 1'b1;
    repeat (6) @(negedge clk);
    i_daclrck = 1'b0;
    repeat (3) @(negedge clk);
    chk("r_pre_dac", int'(o_dac_data), 1600);
    rst_n = 1'b0;
    #1;
    chk("r_busy", int'(o_busy), 0);
    chk("r_dac", int'(o_dac_data), 0);
    chk("r_addr", int'(o_sram_addr), 0);
    chk("r_rd", int'(o_sram_rd), 0);
    chk("r_done", int'(o_done), 0);
    dacq.delete();
    rdq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("r_post_busy", int'(o_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
